rx_packer: RTL and testbench

Receive-side packer sitting directly downstream of the 3-bit transmit stage. Accepts 3-bit symbols over a valid/ready handshake, assembles NSYM consecutive symbols into one word, and presents that word on a second valid/ready handshake to the next consumer. Back-pressure from the word consumer stalls symbol intake; no symbol is dropped or duplicated.

---
 rtl/rx_pkg.sv | 16 +
 rtl/rx_idle_timer.sv | 29 ++
 rtl/rx_packer.sv | 109 ++++++++++
 tb/tb_rx_packer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared types and constants for the rx_packer slice.
package rx_pkg;

  localparam int SYM_W = 3;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } rx_state_e;

  // Width needed to hold a symbol count of 0..nsym inclusive.
  function automatic int cnt_w(input int nsym);
    return $clog2(nsym + 1);
  endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// Idle timer for partial-word flush; only instantiated when RX_PACKER_TIMEOUT_EN is defined.
module rx_idle_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [7:0] TC = 8'(TIMEOUT);

  logic [7:0] idle_q;

  // Saturates at the terminal count so expiry holds until cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_q <= '0;
    end else if (clear) begin
      idle_q <= '0;
    end else if (run && (idle_q != TC)) begin
      idle_q <= idle_q + 8'd1;
    end
  end

  assign expired = run && (idle_q == TC);

endmodule

// File: rtl/rx_packer.sv
// Packs NSYM 3-bit symbols into one word with valid/ready on both sides.
// Optional partial-word flush on idle timeout: define RX_PACKER_TIMEOUT_EN.
//
// state | meaning
// FILL  | accepting symbols into slot cnt
// HOLD  | word presented, waiting for consumer
module rx_packer
  import rx_pkg::*;
#(
  parameter int NSYM    = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_i,
  input  logic [SYM_W-1:0]            data_i,
  output logic                        ready_o,
  output logic                        word_valid_o,
  output logic [SYM_W*NSYM-1:0]       word_o,
  output logic [cnt_w(NSYM)-1:0]      word_cnt_o,
  input  logic                        word_ready_i
);

  localparam int CNT_W = cnt_w(NSYM);

  if (NSYM < 2 || NSYM > 16 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("rx_packer: NSYM or TIMEOUT out of range");
  end

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      word_cnt_q;
  logic [SYM_W*NSYM-1:0] word_q;
  logic                  sym_hs;
  logic                  word_hs;
  logic                  last_sym;
  logic                  flush;

  assign sym_hs   = valid_i && (state_q == FILL);
  assign word_hs  = word_ready_i && (state_q == HOLD);
  assign last_sym = (cnt_q == CNT_W'(NSYM - 1));

`ifdef RX_PACKER_TIMEOUT_EN
  logic expired;

  rx_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (sym_hs || word_hs),
    .run     ((state_q == FILL) && (cnt_q != '0)),
    .expired (expired)
  );

  // A symbol arriving on the expiry cycle is stored rather than flushed.
  assign flush = expired && !sym_hs;
`else
  assign flush = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if ((sym_hs && last_sym) || flush) state_d = HOLD;
      HOLD:    if (word_hs) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q     <= '0;
      cnt_q      <= '0;
      word_cnt_q <= '0;
    end else if (sym_hs) begin
      for (int i = 0; i < NSYM; i++) begin
        if (cnt_q == CNT_W'(i)) word_q[i*SYM_W +: SYM_W] <= data_i;
      end
      if (last_sym) begin
        cnt_q      <= '0;
        word_cnt_q <= CNT_W'(NSYM);
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else if (flush) begin
      word_cnt_q <= cnt_q;
      cnt_q      <= '0;
    end else if (word_hs) begin
      // Cleared so unfilled slots of the next (possibly partial) word read as 0.
      word_q     <= '0;
      word_cnt_q <= '0;
    end
  end

  assign ready_o      = (state_q == FILL);
  assign word_valid_o = (state_q == HOLD);
  assign word_o       = word_q;
  assign word_cnt_o   = word_cnt_q;

endmodule

// File: tb/tb_rx_packer.sv
// Scoreboard bench for rx_packer (NSYM=4, TIMEOUT=8); follows RX_PACKER_TIMEOUT_EN.
module tb_rx_packer;

  localparam int NSYM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic [2:0]  data_i;
  logic        ready_o;
  logic        word_valid_o;
  logic [11:0] word_o;
  logic [2:0]  word_cnt_o;
  logic        word_ready_i;

  typedef struct {
    logic [11:0] w;
    int          c;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_pushed = 0;
  int          n_words  = 0;
  logic [11:0] m_word   = '0;
  int          m_cnt    = 0;
  logic        prev_v   = 1'b0;
  logic [11:0] prev_w   = '0;

  rx_packer #(.NSYM(NSYM), .TIMEOUT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .ready_o      (ready_o),
    .word_valid_o (word_valid_o),
    .word_o       (word_o),
    .word_cnt_o   (word_cnt_o),
    .word_ready_i (word_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic push_exp(input logic [11:0] w, input int c);
    exp_t e;
    e.w = w;
    e.c = c;
    sb_q.push_back(e);
    n_pushed++;
  endtask

  task automatic accept(input logic [2:0] d);
    m_word[m_cnt*3 +: 3] = d;
    m_cnt++;
    if (m_cnt == NSYM) begin
      push_exp(m_word, NSYM);
      m_word = '0;
      m_cnt  = 0;
    end
  endtask

  task automatic send(input logic [2:0] d);
    int guard;
    guard   = 0;
    valid_i = 1'b1;
    data_i  = d;
    forever begin
      @(negedge clk);
      if (ready_o) break;
      guard++;
      if (guard > 50) begin
        chk("send_timeout", guard, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (guard <= 50) accept(d);
    valid_i = 1'b0;
    data_i  = 3'd3;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    data_i  = 3'd3;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (reset && word_valid_o && prev_v) chk("hold_stable", word_o, prev_w);
    if (reset && word_valid_o && word_ready_i) begin
      n_words++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", sb_q.size(), 1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_word", word_o, e.w);
        chk("sb_cnt", word_cnt_o, e.c);
      end
    end
    prev_v = word_valid_o && !word_ready_i;
    prev_w = word_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    valid_i      = 1'b0;
    data_i       = 3'd0;
    word_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_wvalid", word_valid_o, 0);
    chk("rst_word", word_o, 0);
    chk("rst_cnt", word_cnt_o, 0);
    reset = 1'b1;
    idle(1);

    // full word back-to-back, ready_o low for exactly one cycle
    send(3'd1); send(3'd2); send(3'd3); send(3'd4);
    chk("full_wvalid", word_valid_o, 1);
    chk("full_ready_low", ready_o, 0);
    chk("full_word", word_o, 12'b100_011_010_001);
    chk("full_cnt", word_cnt_o, 4);
    @(posedge clk);
    #1;
    chk("full_ready_back", ready_o, 1);
    chk("full_wvalid_drop", word_valid_o, 0);

    // back-pressure with a symbol waiting
    word_ready_i = 1'b0;
    send(3'd1); send(3'd0); send(3'd6); send(3'd2);
    valid_i = 1'b1;
    data_i  = 3'd7;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_ready", ready_o, 0);
      chk("bp_word", word_o, 12'b010_110_000_001);
    end
    word_ready_i = 1'b1;
    send(3'd7); send(3'd1); send(3'd2); send(3'd3);

    // valid gaps with garbage on data_i
    idle(1); send(3'd5); idle(1); send(3'd6); idle(1); send(3'd7); idle(1); send(3'd0);
    chk("gap_word", word_o, 12'b000_111_110_101);

    // reset mid-word discards the partial word
    idle(2);
    send(3'd2); send(3'd3);
    reset = 1'b0;
    m_word = '0;
    m_cnt  = 0;
    #2;
    chk("mid_rst_ready", ready_o, 1);
    chk("mid_rst_wvalid", word_valid_o, 0);
    chk("mid_rst_word", word_o, 0);
    chk("mid_rst_cnt", word_cnt_o, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);
    send(3'd4); send(3'd5); send(3'd6); send(3'd1);

    // idle after a partial word
    idle(2);
`ifdef RX_PACKER_TIMEOUT_EN
    word_ready_i = 1'b0;
    send(3'd3); send(3'd5);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    chk("to_not_yet", word_valid_o, 0);
    @(posedge clk);
    #1;
    chk("to_flush_valid", word_valid_o, 1);
    chk("to_flush_word", word_o, 12'b000_000_101_011);
    chk("to_flush_cnt", word_cnt_o, 2);
    push_exp(m_word, m_cnt);
    m_word = '0;
    m_cnt  = 0;
    word_ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("to_ready_back", ready_o, 1);
    // symbol on the expiry cycle wins over the flush
    send(3'd4);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    send(3'd6);
    chk("to_race_no_flush", word_valid_o, 0);
    send(3'd1); send(3'd2);
    chk("to_race_cnt", word_cnt_o, 4);
`else
    send(3'd3); send(3'd5);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("nto_no_flush", word_valid_o, 0);
    end
    send(3'd1); send(3'd2);
    chk("nto_word", word_o, 12'b010_001_101_011);
    chk("nto_cnt", word_cnt_o, 4);
`endif

    idle(4);
    chk("sb_empty", sb_q.size(), 0);
    chk("words_seen", n_words, n_pushed);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
